// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS pipeline stages.
//   - Datapath and register-index widths.
//   - Bit positions of the fields in the 71-bit memory-stage bundle (membus).
//   - A packed struct that overlays membus, so that stages decode its fields by name.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam int MB_WREG_LSB  = 0;
  localparam int MB_ALU_LSB   = 5;
  localparam int MB_RDATA_LSB = 37;
  localparam int MB_MEMTOREG  = 69;
  localparam int MB_REGWRITE  = 70;
  localparam int MEMBUS_W     = 71;

  // Field order, MSB first, matches the bit positions above.
  typedef struct packed {
    logic              reg_write;   // [70]
    logic              mem_to_reg;  // [69]
    logic [DATA_W-1:0] read_data;   // [68:37]
    logic [DATA_W-1:0] alu_out;     // [36:5]
    logic [ADDR_W-1:0] write_reg;   // [4:0]
  } membus_t;

endpackage

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: architectural register file with two read ports and one write port.
//   clock, reset    : rising-edge clock; synchronous active-high reset clears every register
//   we, waddr, wdata: write port. Writes to index 0 are dropped; reset overrides a write.
//   raddr1, raddr2  : read indices
//   rdata1, rdata2  : combinational read data. Returns 0 during reset and for index 0.
//                     A write presented in the same cycle to the same index is bypassed
//                     to the read port (write-first).
module reg_file_2r1w
  import mips_pkg::*;
#(
  parameter int NUM_REGS = mips_pkg::NUM_REGS,
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr;

  // Reset is tested first so that an X on we during reset cannot reach the array.
  always_comb begin
    wr = 1'b0;
    if (!reset) wr = we && (waddr != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (reset || raddr1 == '0) rdata1 = '0;
    else if (wr && raddr1 == waddr) rdata1 = wdata;
    else rdata1 = regs[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (reset || raddr2 == '0) rdata2 = '0;
    else if (wr && raddr2 == waddr) rdata2 = wdata;
    else rdata2 = regs[raddr2];
  end

endmodule

// File: rtl/instr_writeback.sv
// instr_writeback: writeback stage of the 5-stage MIPS pipeline.
//   clock, reset     : rising-edge clock; synchronous active-high reset
//   membus           : bundle from the memory stage {regWrite, memtoReg, readData, aluOut, writeReg}
//   raddr1/2, rdata1/2: decode-stage read ports into the register file, with same-cycle bypass
//   resultW_wire     : selected writeback result (load data or ALU result), used for forwarding
//   writeRegW_wire   : writeback destination index
//   regWriteW_wire   : writeback write enable
//   wb_count         : number of register-file commits since reset; wraps modulo 2^32
module instr_writeback
  import mips_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [MEMBUS_W-1:0] membus,
  input  logic [ADDR_W-1:0]   raddr1,
  input  logic [ADDR_W-1:0]   raddr2,
  output logic [DATA_W-1:0]   rdata1,
  output logic [DATA_W-1:0]   rdata2,
  output logic [DATA_W-1:0]   resultW_wire,
  output logic [ADDR_W-1:0]   writeRegW_wire,
  output logic                regWriteW_wire,
  output logic [31:0]         wb_count
);

  membus_t     mb;
  logic        commit;
  logic [31:0] commit_count;

  assign mb = membus_t'(membus);

  assign resultW_wire   = mb.mem_to_reg ? mb.read_data : mb.alu_out;
  assign writeRegW_wire = mb.write_reg;
  assign regWriteW_wire = mb.reg_write;

  // Same qualification as the register-file write, so that writes dropped for r0 or
  // discarded by reset are not counted.
  always_comb begin
    commit = 1'b0;
    if (!reset) commit = mb.reg_write && (mb.write_reg != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) commit_count <= '0;
    else if (commit) commit_count <= commit_count + 32'd1;
  end

  assign wb_count = commit_count;

  reg_file_2r1w #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_reg_file (
    .clock  (clock),
    .reset  (reset),
    .we     (mb.reg_write),
    .waddr  (mb.write_reg),
    .wdata  (resultW_wire),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

endmodule

// File: tb/tb_instr_writeback.sv
module tb_instr_writeback;
  import mips_pkg::*;

  logic                clock;
  logic                reset;
  logic [MEMBUS_W-1:0] membus;
  logic [ADDR_W-1:0]   raddr1;
  logic [ADDR_W-1:0]   raddr2;
  logic [DATA_W-1:0]   rdata1;
  logic [DATA_W-1:0]   rdata2;
  logic [DATA_W-1:0]   resultW_wire;
  logic [ADDR_W-1:0]   writeRegW_wire;
  logic                regWriteW_wire;
  logic [31:0]         wb_count;

  int tests_run = 0;
  int tests_failed = 0;

  instr_writeback dut (
    .clock          (clock),
    .reset          (reset),
    .membus         (membus),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
    .resultW_wire   (resultW_wire),
    .writeRegW_wire (writeRegW_wire),
    .regWriteW_wire (regWriteW_wire),
    .wb_count       (wb_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [MEMBUS_W-1:0] mk(input logic rw, input logic m2r,
                                             input logic [31:0] rd, input logic [31:0] alu,
                                             input logic [4:0] wr);
    return {rw, m2r, rd, alu, wr};
  endfunction

  // Advance to just after the next rising edge, where new inputs are driven.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    membus = '0;
    raddr1 = '0;
    raddr2 = '0;
    step();
    step();
    raddr1 = 5'd5;
    #2;
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_count", wb_count, 32'h0);

    // ALU-result write to r5: same-cycle bypass, then read from the array.
    reset  = 1'b0;
    membus = mk(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5);
    #2;
    check("alu_bypass", rdata1, 32'h0000_1234);
    check("alu_result", resultW_wire, 32'h0000_1234);
    check("alu_wreg", {27'd0, writeRegW_wire}, 32'd5);
    check("alu_regwrite", {31'd0, regWriteW_wire}, 32'd1);
    step();
    membus = '0;
    #2;
    check("alu_array", rdata1, 32'h0000_1234);
    check("alu_count", wb_count, 32'd1);

    // regWrite low: no bypass, array value still returned.
    membus = mk(1'b0, 1'b0, 32'h0, 32'h0000_ABCD, 5'd5);
    #2;
    check("nowrite_no_bypass", rdata1, 32'h0000_1234);
    check("nowrite_regwrite", {31'd0, regWriteW_wire}, 32'd0);
    step();
    check("nowrite_count", wb_count, 32'd1);

    // Load path to r7.
    membus = mk(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0010, 5'd7);
    raddr2 = 5'd7;
    #2;
    check("load_result", resultW_wire, 32'hDEAD_BEEF);
    check("load_bypass", rdata2, 32'hDEAD_BEEF);
    step();
    membus = '0;
    #2;
    check("load_array", rdata2, 32'hDEAD_BEEF);
    check("load_count", wb_count, 32'd2);

    // Write to r0 is dropped and not counted.
    membus = mk(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
    raddr1 = 5'd0;
    #2;
    check("r0_write_cycle", rdata1, 32'h0);
    check("r0_result", resultW_wire, 32'hFFFF_FFFF);
    step();
    membus = '0;
    #2;
    check("r0_next_cycle", rdata1, 32'h0);
    check("r0_count", wb_count, 32'd2);

    // Back-to-back writes to r3, both ports reading r3.
    raddr1 = 5'd3;
    raddr2 = 5'd3;
    membus = mk(1'b1, 1'b0, 32'h0, 32'h0000_0011, 5'd3);
    #2;
    check("b2b_first_p1", rdata1, 32'h11);
    check("b2b_first_p2", rdata2, 32'h11);
    step();
    membus = mk(1'b1, 1'b0, 32'h0, 32'h0000_0022, 5'd3);
    #2;
    check("b2b_second_p1", rdata1, 32'h22);
    check("b2b_second_p2", rdata2, 32'h22);
    step();
    membus = '0;
    #2;
    check("b2b_persist_p1", rdata1, 32'h22);
    check("b2b_persist_p2", rdata2, 32'h22);
    check("b2b_count", wb_count, 32'd4);

    // r9 = 0x99, then reset while membus writes r9 = 0x55.
    membus = mk(1'b1, 1'b0, 32'h0, 32'h0000_0099, 5'd9);
    step();
    membus = '0;
    raddr1 = 5'd9;
    raddr2 = 5'd5;
    #2;
    check("r9_preload", rdata1, 32'h99);
    check("r9_count", wb_count, 32'd5);
    reset  = 1'b1;
    membus = mk(1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd9);
    #2;
    check("rst_cycle_p1", rdata1, 32'h0);
    check("rst_cycle_p2", rdata2, 32'h0);
    step();
    reset  = 1'b0;
    membus = '0;
    #2;
    check("rst_r9", rdata1, 32'h0);
    check("rst_count", wb_count, 32'h0);
    for (int i = 1; i < NUM_REGS; i++) begin
      raddr2 = 5'(i);
      #1;
      check($sformatf("rst_all_r%0d", i), rdata2, 32'h0);
    end

    // Counter wrap.
    force dut.commit_count = 32'hFFFF_FFFF;
    #1;
    release dut.commit_count;
    #1;
    check("wrap_preload", wb_count, 32'hFFFF_FFFF);
    membus = mk(1'b1, 1'b0, 32'h0, 32'h0000_0007, 5'd1);
    step();
    membus = '0;
    raddr1 = 5'd1;
    #2;
    check("wrap_count", wb_count, 32'h0);
    check("wrap_r1", rdata1, 32'h7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
